match_flow_ctl: RTL and testbench

- Game-flow scheduler for the air-hockey table.
- Sequences the ball physics datapath through idle, serve countdown, live play, post-goal freeze and game over.
- Owns both players' scores and decides the winner.
- Sits between the ball controller (consumes ball_rst/ball_en, produces goal pulses) and the score/text overlay.

---
 rtl/match_flow_ctl_pkg.sv | 41 ++++
 rtl/match_flow_ctl_if.sv | 28 ++
 rtl/match_flow_ctl_frame_down_counter.sv | 26 ++
 rtl/match_flow_ctl.sv | 188 ++++++++++++++++++
 tb/tb_match_flow_ctl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/match_flow_ctl_pkg.sv
// Shared types and constants for the air-hockey match flow controller.
package air_hockey_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    GOAL  = 3'd3,
    OVER  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_e;

  localparam logic [9:0] CENTRE_X = 10'd487;
  localparam logic [9:0] CENTRE_Y = 10'd362;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  function automatic winner_e winner_of(input logic [3:0] p1, input logic [3:0] p2);
    if (p1 > p2)      return WIN_P1;
    else if (p2 > p1) return WIN_P2;
    else              return WIN_DRAW;
  endfunction

  // {ball_rst, ball_en} per state; unknown codes hold the ball at centre.
  function automatic logic [1:0] ball_ctl(input state_e s);
    case (s)
      PLAY:    return 2'b01;
      GOAL:    return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/match_flow_ctl_if.sv
// Bundle between the match flow controller and the ball/overlay logic.
interface match_flow_ctl_if;
  logic       frame_tick;
  logic       start_btn;
  logic       goal_p1;
  logic       goal_p2;
  logic       ball_rst;
  logic       ball_en;
  logic       serve_to;
  logic [3:0] player_1_score;
  logic [3:0] player_2_score;
  logic [1:0] winner;
  logic [2:0] match_state;
  logic [7:0] frames_left;
  logic [7:0] time_left;

  modport master (
    output frame_tick, start_btn, goal_p1, goal_p2,
    input  ball_rst, ball_en, serve_to, player_1_score, player_2_score,
           winner, match_state, frames_left, time_left
  );

  modport slave (
    input  frame_tick, start_btn, goal_p1, goal_p2,
    output ball_rst, ball_en, serve_to, player_1_score, player_2_score,
           winner, match_state, frames_left, time_left
  );
endinterface

// File: rtl/match_flow_ctl_frame_down_counter.sv
// 8-bit loadable down counter stepped by frame ticks; stops at zero.
module frame_down_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       en_i,
  output logic [7:0] value_o,
  output logic       zero_o
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)  cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);
endmodule

// File: rtl/match_flow_ctl.sv
// Air-hockey game-flow scheduler: serve, play, goal freeze, game over, scores.
// Optional match timer enabled by defining AIR_HOCKEY_MATCH_TIMER_EN.
module match_flow_ctl
  import air_hockey_pkg::*;
#(
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned SERVE_FRAMES   = 120,
  parameter int unsigned GOAL_FRAMES    = 90,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned MATCH_SECONDS  = 180
) (
  input logic             clk_in,
  input logic             rst_n,
  match_flow_ctl_if.slave mf
);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] GOAL_LOAD  = 8'(GOAL_FRAMES - 1);
  localparam logic [3:0] WIN_PTS    = 4'(WIN_SCORE);

  state_e     state_q, state_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  winner_e    win_q, win_d;
  logic       serve_q, serve_d;
  logic       start_q;
  logic       ball_rst_q, ball_en_q;
  logic       start_edge;

  logic       cnt_load;
  logic [7:0] cnt_val;
  logic [7:0] cnt_value;
  logic       cnt_zero;

  assign start_edge = mf.start_btn & ~start_q;

  frame_down_counter u_frame_cnt (
    .clk_i      (clk_in),
    .rst_ni     (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (mf.frame_tick),
    .value_o    (cnt_value),
    .zero_o     (cnt_zero)
  );

`ifdef AIR_HOCKEY_MATCH_TIMER_EN
  localparam logic [7:0] PRESC_LOAD = 8'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] MATCH_LOAD = 8'(MATCH_SECONDS);

  logic [7:0] time_q, time_d;
  logic       ps_load, ps_en, ps_zero;
  logic [7:0] presc_unused;

  assign ps_en = mf.frame_tick && (state_q == PLAY);

  frame_down_counter u_presc (
    .clk_i      (clk_in),
    .rst_ni     (rst_n),
    .load_i     (ps_load),
    .load_val_i (PRESC_LOAD),
    .en_i       (ps_en),
    .value_o    (presc_unused),
    .zero_o     (ps_zero)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n) time_q <= '0;
    else        time_q <= time_d;
  end

  assign mf.time_left = time_q;
`else
  localparam int unsigned TIMER_CFG_UNUSED = FRAMES_PER_SEC + MATCH_SECONDS;
  assign mf.time_left = '0;
`endif

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    win_d    = win_q;
    serve_d  = serve_q;
    cnt_load = 1'b0;
    cnt_val  = SERVE_LOAD;
`ifdef AIR_HOCKEY_MATCH_TIMER_EN
    time_d   = time_q;
    ps_load  = 1'b0;
`endif
    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          state_d  = SERVE;
          p1_d     = '0;
          p2_d     = '0;
          win_d    = WIN_NONE;
          serve_d  = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = SERVE_LOAD;
`ifdef AIR_HOCKEY_MATCH_TIMER_EN
          time_d   = MATCH_LOAD;
          ps_load  = 1'b1;
`endif
        end
      end
      SERVE: begin
        if (mf.frame_tick && cnt_zero) state_d = PLAY;
      end
      PLAY: begin
        if (mf.goal_p1) begin
          p1_d     = sat_inc(p1_q);
          serve_d  = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = GOAL_LOAD;
          state_d  = GOAL;
        end else if (mf.goal_p2) begin
          p2_d     = sat_inc(p2_q);
          serve_d  = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = GOAL_LOAD;
          state_d  = GOAL;
        end
`ifdef AIR_HOCKEY_MATCH_TIMER_EN
        // Expiry overrides a coincident goal's GOAL entry but keeps its score.
        if (mf.frame_tick && ps_zero) begin
          ps_load = 1'b1;
          time_d  = (time_q == '0) ? '0 : time_q - 8'd1;
          if (time_d == '0) begin
            state_d  = OVER;
            win_d    = winner_of(p1_d, p2_d);
            cnt_load = 1'b1;
            cnt_val  = '0;
          end
        end
`endif
      end
      GOAL: begin
        if (mf.frame_tick && cnt_zero) begin
          if (p1_q == WIN_PTS) begin
            state_d = OVER;
            win_d   = WIN_P1;
          end else if (p2_q == WIN_PTS) begin
            state_d = OVER;
            win_d   = WIN_P2;
          end else begin
            state_d  = SERVE;
            cnt_load = 1'b1;
            cnt_val  = SERVE_LOAD;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_load = 1'b1;
        cnt_val  = '0;
      end
    endcase
  end

  // start_q resets high so a button held through reset needs a release first.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      p1_q       <= '0;
      p2_q       <= '0;
      win_q      <= WIN_NONE;
      serve_q    <= 1'b0;
      start_q    <= 1'b1;
      ball_rst_q <= 1'b1;
      ball_en_q  <= 1'b0;
    end else begin
      state_q                 <= state_d;
      p1_q                    <= p1_d;
      p2_q                    <= p2_d;
      win_q                   <= win_d;
      serve_q                 <= serve_d;
      start_q                 <= mf.start_btn;
      {ball_rst_q, ball_en_q} <= ball_ctl(state_d);
    end
  end

  assign mf.ball_rst       = ball_rst_q;
  assign mf.ball_en        = ball_en_q;
  assign mf.serve_to       = serve_q;
  assign mf.player_1_score = p1_q;
  assign mf.player_2_score = p2_q;
  assign mf.winner         = win_q;
  assign mf.match_state    = state_q;
  assign mf.frames_left    = cnt_value;
endmodule

// File: tb/tb_match_flow_ctl.sv
// Directed scoreboard bench for match_flow_ctl (WIN_SCORE=3, short serve/goal delays).
module tb_match_flow_ctl;
  import air_hockey_pkg::*;

  localparam int unsigned WIN = 3;
  localparam int unsigned SF  = 4;
  localparam int unsigned GF  = 3;
  localparam int unsigned FPS = 4;
  localparam int unsigned MS  = 2;
`ifdef AIR_HOCKEY_MATCH_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  match_flow_ctl_if mf ();

  match_flow_ctl #(
    .WIN_SCORE      (WIN),
    .SERVE_FRAMES   (SF),
    .GOAL_FRAMES    (GF),
    .FRAMES_PER_SEC (FPS),
    .MATCH_SECONDS  (MS)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .mf     (mf)
  );

  always #5 clk_in = ~clk_in;

  typedef enum int {O_STATE, O_RST, O_EN, O_SERVE, O_P1, O_P2, O_WIN, O_FRAMES, O_TIME} obs_e;
  typedef struct {
    string       tag;
    obs_e        sel;
    int unsigned val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] observe(obs_e s);
    case (s)
      O_STATE:  return 32'(mf.match_state);
      O_RST:    return 32'(mf.ball_rst);
      O_EN:     return 32'(mf.ball_en);
      O_SERVE:  return 32'(mf.serve_to);
      O_P1:     return 32'(mf.player_1_score);
      O_P2:     return 32'(mf.player_2_score);
      O_WIN:    return 32'(mf.winner);
      O_FRAMES: return 32'(mf.frames_left);
      default:  return 32'(mf.time_left);
    endcase
  endfunction

  task automatic want(input string tag, input obs_e sel, input int unsigned val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === 32'(e.val)) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic tick();
    mf.frame_tick = 1'b1;
    step();
    mf.frame_tick = 1'b0;
    step();
  endtask

  task automatic serve_to_play();
    for (int i = 0; i < int'(SF); i++) begin
      want("serve_frames", O_FRAMES, SF - 1 - i);
      want("serve_state", O_STATE, SERVE);
      want("serve_ball_rst", O_RST, 1);
      drain();
      tick();
    end
    want("play_state", O_STATE, PLAY);
    want("play_ball_en", O_EN, 1);
    want("play_ball_rst", O_RST, 0);
    want("play_frames", O_FRAMES, 0);
    drain();
  endtask

  task automatic goal_wait();
    for (int i = 0; i < int'(GF); i++) begin
      want("goal_frames", O_FRAMES, GF - 1 - i);
      want("goal_state", O_STATE, GOAL);
      want("goal_ball_en", O_EN, 0);
      want("goal_ball_rst", O_RST, 0);
      drain();
      tick();
    end
  endtask

  task automatic expect_reserve();
    want("reserve_state", O_STATE, SERVE);
    want("reserve_frames", O_FRAMES, SF - 1);
    want("reserve_ball_rst", O_RST, 1);
    drain();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mf.frame_tick = 1'b0;
    mf.start_btn  = 1'b1;
    mf.goal_p1    = 1'b0;
    mf.goal_p2    = 1'b0;
    rst_n         = 1'b0;
    repeat (3) step();

    // Reset state, with start held through reset
    rst_n = 1'b1;
    want("rst_state", O_STATE, IDLE);
    want("rst_ball_rst", O_RST, 1);
    want("rst_ball_en", O_EN, 0);
    want("rst_p1", O_P1, 0);
    want("rst_p2", O_P2, 0);
    want("rst_winner", O_WIN, WIN_NONE);
    want("rst_serve", O_SERVE, 0);
    want("rst_frames", O_FRAMES, 0);
    want("rst_time", O_TIME, 0);
    step();
    drain();
    repeat (2) begin
      want("held_start_idle", O_STATE, IDLE);
      step();
      drain();
    end
    mf.start_btn = 1'b0;
    want("start_low_idle", O_STATE, IDLE);
    step();
    drain();

    // Start edge into SERVE, then PLAY
    mf.start_btn = 1'b1;
    want("start_state", O_STATE, SERVE);
    want("start_frames", O_FRAMES, SF - 1);
    want("start_serve_to", O_SERVE, 0);
    want("start_ball_en", O_EN, 0);
    want("start_time", O_TIME, TIMER ? MS : 0);
    step();
    drain();
    serve_to_play();

    // Start edge ignored in PLAY
    mf.start_btn = 1'b0;
    step();
    mf.start_btn = 1'b1;
    want("play_start_ignored", O_STATE, PLAY);
    step();
    drain();

    // goal_p2: conceding player 1 serves
    mf.goal_p2 = 1'b1;
    want("g2_state", O_STATE, GOAL);
    want("g2_p2", O_P2, 1);
    want("g2_p1", O_P1, 0);
    want("g2_serve_to", O_SERVE, 0);
    want("g2_frames", O_FRAMES, GF - 1);
    step();
    mf.goal_p2 = 1'b0;
    drain();
    mf.goal_p1 = 1'b1;
    want("goal_in_goal_p1", O_P1, 0);
    want("goal_in_goal_state", O_STATE, GOAL);
    step();
    mf.goal_p1 = 1'b0;
    drain();
    goal_wait();
    expect_reserve();
    serve_to_play();

    // Simultaneous goals with a coincident frame tick
    mf.goal_p1    = 1'b1;
    mf.goal_p2    = 1'b1;
    mf.frame_tick = 1'b1;
    want("both_state", O_STATE, GOAL);
    want("both_p1", O_P1, 1);
    want("both_p2", O_P2, 1);
    want("both_serve_to", O_SERVE, 1);
    want("both_frames", O_FRAMES, GF - 1);
    step();
    mf.goal_p1    = 1'b0;
    mf.goal_p2    = 1'b0;
    mf.frame_tick = 1'b0;
    drain();
    goal_wait();
    expect_reserve();
    serve_to_play();

    // Player 1 reaches WIN_SCORE
    mf.goal_p1 = 1'b1;
    want("p1_second", O_P1, 2);
    step();
    mf.goal_p1 = 1'b0;
    drain();
    goal_wait();
    expect_reserve();
    serve_to_play();
    mf.goal_p1 = 1'b1;
    want("p1_third", O_P1, WIN);
    want("p1_third_state", O_STATE, GOAL);
    step();
    mf.goal_p1 = 1'b0;
    drain();
    goal_wait();
    want("over_state", O_STATE, OVER);
    want("over_winner", O_WIN, WIN_P1);
    want("over_ball_rst", O_RST, 1);
    want("over_ball_en", O_EN, 0);
    want("over_frames", O_FRAMES, 0);
    drain();
    mf.goal_p2 = 1'b1;
    want("over_goal_ignored", O_P2, 1);
    want("over_goal_state", O_STATE, OVER);
    step();
    mf.goal_p2 = 1'b0;
    drain();

    // Restart from OVER clears the match
    mf.start_btn = 1'b0;
    step();
    mf.start_btn = 1'b1;
    want("restart_state", O_STATE, SERVE);
    want("restart_p1", O_P1, 0);
    want("restart_p2", O_P2, 0);
    want("restart_winner", O_WIN, WIN_NONE);
    want("restart_serve_to", O_SERVE, 0);
    want("restart_frames", O_FRAMES, SF - 1);
    want("restart_time", O_TIME, TIMER ? MS : 0);
    step();
    drain();

    // Level the score 1:1, then run the match clock down in PLAY
    serve_to_play();
    mf.goal_p1 = 1'b1;
    want("lvl_p1", O_P1, 1);
    step();
    mf.goal_p1 = 1'b0;
    drain();
    goal_wait();
    expect_reserve();
    serve_to_play();
    mf.goal_p2 = 1'b1;
    want("lvl_p2", O_P2, 1);
    step();
    mf.goal_p2 = 1'b0;
    drain();
    goal_wait();
    expect_reserve();
    serve_to_play();
    want("timer_paused", O_TIME, TIMER ? MS : 0);
    drain();
    for (int i = 1; i <= int'(MS * FPS); i++) begin
      tick();
      if (i == int'(FPS)) begin
        want("timer_one_sec", O_TIME, TIMER ? MS - 1 : 0);
        want("timer_mid_state", O_STATE, PLAY);
        drain();
      end
    end
    want("timeout_state", O_STATE, TIMER ? OVER : PLAY);
    want("timeout_winner", O_WIN, TIMER ? WIN_DRAW : WIN_NONE);
    want("timeout_time", O_TIME, 0);
    want("timeout_ball_rst", O_RST, TIMER ? 1 : 0);
    want("timeout_frames", O_FRAMES, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
